// File: rtl/multiplexor_nin_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multiplexor_nin_reg_pkg
//  Purpose  : Shared constants for the N-input registered multiplexer.
//             MODE_SEL selects the explicit-select decode, MODE_RR selects
//             round-robin arbitration among valid inputs.
//  Revision : 1.0  initial release
// ============================================================================
package multiplexor_nin_reg_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

endpackage
`default_nettype wire

// File: rtl/multiplexor_nin_reg_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_n
//  Purpose  : Combinational round-robin arbiter. Scans ptr_i, ptr_i+1, ...
//             wrapping at N_IN, and picks the first channel whose valid bit
//             is set.
//  Ports    : valido_i  [N_IN]   per-channel request
//             ptr_i     [SEL_W]  channel with highest priority this cycle
//             enable_i           allows the one-hot grant to be asserted
//             grant_o   [N_IN]   one-hot grant (zero when disabled/no hit)
//             index_o   [SEL_W]  index of the winning channel
//             hit_o              some channel requested
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_n #(
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic [N_IN-1:0]  valido_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             enable_i,
    output logic [N_IN-1:0]  grant_o,
    output logic [SEL_W-1:0] index_o,
    output logic             hit_o
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [SEL_W:0] w_idx;

    always_comb begin
        grant_o = '0;
        index_o = '0;
        hit_o   = 1'b0;
        w_idx   = '0;
        // Scan from the farthest offset down so the nearest valid channel
        // (smallest offset from ptr) is the last one written and wins.
        for (int j = N_IN - 1; j >= 0; j--) begin
            w_idx = {1'b0, ptr_i} + (SEL_W+1)'(j);
            if (w_idx >= (SEL_W+1)'(N_IN)) begin
                w_idx = w_idx - (SEL_W+1)'(N_IN);
            end
            if (valido_i[w_idx[SEL_W-1:0]]) begin
                index_o = w_idx[SEL_W-1:0];
                hit_o   = 1'b1;
            end
        end
        if (enable_i && hit_o) begin
            grant_o[index_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/multiplexor_nin_reg.sv
`default_nettype none
// ============================================================================
//  Module   : multiplexor_nin_reg
//  Purpose  : N-input, WIDTH-bit registered multiplexer with per-input
//             valid/ready handshake and a one-entry output register
//             (latency 1). MODE_SEL uses Sel, MODE_RR arbitrates round-robin.
//  Ports    : clk, reset (sync, active-high)
//             DatoIn   [N_IN*WIDTH] flattened channel data
//             ValidoIn [N_IN]       channel holds a word
//             ListoIn  [N_IN]       channel word consumed this cycle
//             Sel      [SEL_W]      channel select (MODE_SEL only)
//             Salida   [WIDTH]      registered output word
//             SalidaValida          Salida holds an unconsumed word
//             SalidaListo           downstream accepts Salida
//             Indice   [SEL_W]      channel that produced Salida
//  Revision : 1.0  initial release
// ============================================================================
module multiplexor_nin_reg
    import multiplexor_nin_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = MODE_SEL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN*WIDTH-1:0]   DatoIn,
    input  logic [N_IN-1:0]         ValidoIn,
    output logic [N_IN-1:0]         ListoIn,
    input  logic [SEL_W-1:0]        Sel,
    output logic [WIDTH-1:0]        Salida,
    output logic                    SalidaValida,
    input  logic                    SalidaListo,
    output logic [SEL_W-1:0]        Indice
);

    logic [WIDTH-1:0] salida_q, salida_d;
    logic             valida_q, valida_d;
    logic [SEL_W-1:0] indice_q, indice_d;

    logic             w_load;
    logic             w_hit;
    logic             w_xfer;
    logic [SEL_W-1:0] w_idx_g;
    logic [WIDTH-1:0] w_dato;

    // The output register can take a new word when it is empty or being
    // drained this same cycle; this is what gives bubble-free throughput.
    assign w_load = ~valida_q | SalidaListo;
    assign w_xfer = w_load & w_hit & ~reset;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr_q, ptr_d;
            logic             w_unused_sel;

            assign w_unused_sel = ^Sel;

            rr_arbiter_n #(
                .N_IN  (N_IN),
                .SEL_W (SEL_W)
            ) u_arb (
                .valido_i (ValidoIn),
                .ptr_i    (ptr_q),
                .enable_i (w_load & ~reset),
                .grant_o  (ListoIn),
                .index_o  (w_idx_g),
                .hit_o    (w_hit)
            );

            // Pointer advances past the winner only on an actual transfer.
            always_comb begin
                ptr_d = ptr_q;
                if (w_xfer) begin
                    ptr_d = (w_idx_g == SEL_W'(N_IN - 1)) ? '0 : w_idx_g + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_sel
            // Zero-padding to the full Sel range makes Sel >= N_IN read as
            // "not valid" without an out-of-range index.
            logic [(2**SEL_W)-1:0] w_vpad;

            assign w_vpad  = (2**SEL_W)'(ValidoIn);
            assign w_hit   = w_vpad[Sel];
            assign w_idx_g = Sel;

            always_comb begin
                ListoIn = '0;
                for (int i = 0; i < N_IN; i++) begin
                    ListoIn[i] = w_xfer && (Sel == SEL_W'(i));
                end
            end
        end
    endgenerate

    always_comb begin
        w_dato = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_idx_g == SEL_W'(i)) begin
                w_dato = DatoIn[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        salida_d = salida_q;
        valida_d = valida_q;
        indice_d = indice_q;
        if (w_load) begin
            if (w_hit) begin
                salida_d = w_dato;
                indice_d = w_idx_g;
                valida_d = 1'b1;
            end else begin
                valida_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            salida_q <= '0;
            valida_q <= 1'b0;
            indice_q <= '0;
        end else begin
            salida_q <= salida_d;
            valida_q <= valida_d;
            indice_q <= indice_d;
        end
    end

    assign Salida       = salida_q;
    assign SalidaValida = valida_q;
    assign Indice       = indice_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplexor_nin_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiplexor_nin_reg
//  Purpose  : Self-checking bench for multiplexor_nin_reg. Three instances:
//             k=0 explicit select N_IN=4, k=1 round-robin N_IN=4,
//             k=2 explicit select N_IN=3. Directed scenarios then random
//             traffic, all compared against a cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multiplexor_nin_reg;
    import multiplexor_nin_reg_pkg::*;

    localparam int NN [3] = '{4, 4, 3};
    localparam int MD [3] = '{MODE_SEL, MODE_RR, MODE_SEL};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] word [3][4];
    logic [3:0]  vin  [3];
    logic [1:0]  sel  [3];
    logic [2:0]  sl;

    logic [63:0] din0, din1;
    logic [47:0] din2;
    assign din0 = {word[0][3], word[0][2], word[0][1], word[0][0]};
    assign din1 = {word[1][3], word[1][2], word[1][1], word[1][0]};
    assign din2 = {word[2][2], word[2][1], word[2][0]};

    logic [3:0]  lst0, lst1;
    logic [2:0]  lst2;
    logic [15:0] sal0, sal1, sal2;
    logic        sv0, sv1, sv2;
    logic [1:0]  ind0, ind1, ind2;

    multiplexor_nin_reg #(.WIDTH(16), .N_IN(4), .SEL_W(2), .MODE(MODE_SEL)) dut0 (
        .clk(clk), .reset(reset), .DatoIn(din0), .ValidoIn(vin[0]), .ListoIn(lst0),
        .Sel(sel[0]), .Salida(sal0), .SalidaValida(sv0), .SalidaListo(sl[0]), .Indice(ind0));

    multiplexor_nin_reg #(.WIDTH(16), .N_IN(4), .SEL_W(2), .MODE(MODE_RR)) dut1 (
        .clk(clk), .reset(reset), .DatoIn(din1), .ValidoIn(vin[1]), .ListoIn(lst1),
        .Sel(sel[1]), .Salida(sal1), .SalidaValida(sv1), .SalidaListo(sl[1]), .Indice(ind1));

    multiplexor_nin_reg #(.WIDTH(16), .N_IN(3), .SEL_W(2), .MODE(MODE_SEL)) dut2 (
        .clk(clk), .reset(reset), .DatoIn(din2), .ValidoIn(vin[2][2:0]), .ListoIn(lst2),
        .Sel(sel[2]), .Salida(sal2), .SalidaValida(sv2), .SalidaListo(sl[2]), .Indice(ind2));

    // Reference model state: held word, its validity, its source, RR pointer.
    logic [15:0] m_d [3];
    logic        m_v [3];
    int          m_i [3];
    int          m_p [3];
    logic [3:0]  last_lst [3];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Which channel the rules say wins this cycle, -1 for none.
    function automatic int model_grant(input int k);
        int n;
        n = NN[k];
        if (MD[k] == MODE_SEL) begin
            if (int'(sel[k]) < n && vin[k][sel[k]]) return int'(sel[k]);
            return -1;
        end
        for (int j = 0; j < n; j++) begin
            int c;
            c = (m_p[k] + j) % n;
            if (vin[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic step();
        int         g;
        logic       load;
        logic [3:0] el;
        logic [3:0] got;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            g    = model_grant(k);
            load = !m_v[k] || sl[k];
            el   = '0;
            if (!reset && load && g >= 0) el[g] = 1'b1;
            got  = (k == 0) ? lst0 : (k == 1) ? lst1 : {1'b0, lst2};
            last_lst[k] = got;
            chk($sformatf("ListoIn[%0d]", k), 32'(got), 32'(el));
            if (reset) begin
                m_v[k] = 1'b0; m_d[k] = '0; m_i[k] = 0; m_p[k] = 0;
            end else if (load) begin
                if (g >= 0) begin
                    m_d[k] = word[k][g];
                    m_i[k] = g;
                    m_v[k] = 1'b1;
                    m_p[k] = (g + 1) % NN[k];
                end else begin
                    m_v[k] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("Salida[0]", 32'(sal0), 32'(m_d[0]));
        chk("Salida[1]", 32'(sal1), 32'(m_d[1]));
        chk("Salida[2]", 32'(sal2), 32'(m_d[2]));
        chk("SalidaValida[0]", 32'(sv0), 32'(m_v[0]));
        chk("SalidaValida[1]", 32'(sv1), 32'(m_v[1]));
        chk("SalidaValida[2]", 32'(sv2), 32'(m_v[2]));
        chk("Indice[0]", 32'(ind0), 32'(m_i[0]));
        chk("Indice[1]", 32'(ind1), 32'(m_i[1]));
        chk("Indice[2]", 32'(ind2), 32'(m_i[2]));
    endtask

    logic [1:0] exp_rr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        reset = 1'b1;
        sl    = '0;
        for (int k = 0; k < 3; k++) begin
            vin[k] = '0; sel[k] = '0;
            m_d[k] = '0; m_v[k] = 1'b0; m_i[k] = 0; m_p[k] = 0;
            for (int i = 0; i < 4; i++) word[k][i] = '0;
        end

        // Reset state
        step(); step();
        chk("rst_sal0", 32'(sal0), 32'h0);
        chk("rst_sv0",  32'(sv0),  32'h0);
        chk("rst_lst0", 32'(last_lst[0]), 32'h0);
        reset = 1'b0;

        // Explicit select, channel 2
        sel[0] = 2'd2; vin[0] = 4'b0100; word[0][2] = 16'hBEEF; sl[0] = 1'b1;
        step();
        chk("sel_lst0", 32'(last_lst[0]), 32'h4);
        chk("sel_sal0", 32'(sal0), 32'hBEEF);
        chk("sel_ind0", 32'(ind0), 32'd2);
        chk("sel_sv0",  32'(sv0),  32'h1);

        // Stall three cycles, then consume and refill on the same edge
        word[0][2] = 16'h1234; sl[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_lst0", 32'(last_lst[0]), 32'h0);
            chk("stall_sal0", 32'(sal0), 32'hBEEF);
        end
        sl[0] = 1'b1;
        step();
        chk("refill_sal0", 32'(sal0), 32'h1234);
        chk("refill_sv0",  32'(sv0),  32'h1);
        vin[0] = '0;
        step();

        // Round-robin over all four channels
        for (int i = 0; i < 4; i++) word[1][i] = 16'h1000 + 16'(i);
        vin[1] = 4'b1111; sl[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("rr_ind1", 32'(ind1), 32'(exp_rr[c]));
            chk("rr_sal1", 32'(sal1), 32'h1000 + 32'(exp_rr[c]));
        end

        // Drive pointer to 3, then wrap to channel 0 and on to channel 2
        vin[1] = 4'b0100;
        step();
        vin[1] = 4'b0101;
        step();
        chk("wrap_ind1", 32'(ind1), 32'd0);
        step();
        chk("wrap2_ind1", 32'(ind1), 32'd2);
        vin[1] = '0;
        step();

        // Three-channel instance: out-of-range select never grants
        word[2][1] = 16'h00A1; word[2][0] = 16'h00B0;
        vin[2] = 4'b0111; sel[2] = 2'd1; sl[2] = 1'b1;
        step();
        chk("n3_sv2", 32'(sv2), 32'h1);
        sel[2] = 2'd3;
        step();
        chk("n3_oor_lst2", 32'(last_lst[2]), 32'h0);
        chk("n3_oor_sv2",  32'(sv2), 32'h0);
        chk("n3_oor_sal2", 32'(sal2), 32'h00A1);
        sel[2] = 2'd0; sl[2] = 1'b0;
        step();
        chk("n3_fill_sv2", 32'(sv2), 32'h1);
        reset = 1'b1;
        step();
        chk("n3_rst_sv2",  32'(sv2), 32'h0);
        chk("n3_rst_lst2", 32'(last_lst[2]), 32'h0);
        reset = 1'b0;

        // Random traffic on all instances
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int k = 0; k < 3; k++) begin
                vin[k] = 4'($urandom);
                sel[k] = 2'($urandom);
                sl[k]  = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) word[k][i] = 16'($urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
